// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO and a per-frame selectable format.
// The format and baud divisor are latched when a byte is popped, so frames already on the line are unaffected.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic [CNT_W-1:0]         cfg_clk_per_bit,
    input  logic [1:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full, r_empty, r_ovf;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt, r_div;
    logic [2:0]       r_bit_idx, r_last_idx;
    logic [7:0]       r_byte;
    logic             r_par_en, r_par_odd, r_stop2, r_stop_idx;
    logic             r_tx, r_busy;

    logic             w_push, w_pop, w_bit_end, w_tx_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [7:0]       w_mask;
    logic [CNT_W-1:0] w_div;

    assign w_push      = wr_en && !r_full;
    assign w_bit_end   = (r_cnt == r_div - CNT_W'(1));
    assign w_pop       = !r_empty && ((r_state == S_IDLE) ||
                         (r_state == S_STOP && w_bit_end && (!r_stop2 || r_stop_idx)));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_div       = (cfg_clk_per_bit == '0) ? CNT_W'(1) : cfg_clk_per_bit;

    always_comb begin
        w_mask = 8'hFF;
        case (cfg_data_bits)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= wr_en && r_full;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= CNT_W'(1);
            r_bit_idx  <= '0;
            r_last_idx <= '0;
            r_byte     <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            if (r_state != S_IDLE) r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
            case (r_state)
                S_START: if (w_bit_end) begin
                    r_bit_idx <= '0;
                    r_state   <= S_DATA;
                end
                S_DATA: if (w_bit_end) begin
                    if (r_bit_idx == r_last_idx) r_state <= r_par_en ? S_PARITY : S_STOP;
                    else                         r_bit_idx <= r_bit_idx + 3'd1;
                end
                S_PARITY: if (w_bit_end) r_state <= S_STOP;
                S_STOP: if (w_bit_end) begin
                    if (r_stop2 && !r_stop_idx) r_stop_idx <= 1'b1;
                    else                        r_state    <= S_IDLE;
                end
                default: ;
            endcase
            // A pop from IDLE or from the final stop bit starts the next frame with zero gap.
            if (w_pop) begin
                r_state    <= S_START;
                r_cnt      <= '0;
                r_div      <= w_div;
                r_byte     <= r_mem[r_rd_ptr] & w_mask;
                r_last_idx <= 3'd4 + {1'b0, cfg_data_bits};
                r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                r_par_odd  <= (cfg_parity == 2'b10);
                r_stop2    <= cfg_stop2;
                r_stop_idx <= 1'b0;
            end
        end
    end

    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_byte[r_bit_idx];
            S_PARITY: w_tx_nxt = (^r_byte) ^ r_par_odd;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= (r_state != S_IDLE);
        end
    end

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level line model checked every cycle, plus literal frame checks.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic clk, reset_n, wr_en, cfg_stop2;
    logic [7:0] wr_data;
    logic [CNT_W-1:0] cfg_clk_per_bit;
    logic [1:0] cfg_data_bits, cfg_parity;
    logic tx, tx_busy, fifo_full, fifo_empty, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .cfg_clk_per_bit(cfg_clk_per_bit), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus a queue of per-cycle line levels for frames already popped.
    logic [7:0] mq[$];
    bit         wave[$];
    logic       m_tx, m_busy, m_ovf;

    task automatic build(input logic [7:0] b);
        int d, n;
        bit line[$];
        bit p;
        d = (cfg_clk_per_bit == 0) ? 1 : int'(cfg_clk_per_bit);
        n = 5 + int'(cfg_data_bits);
        p = (cfg_parity == 2'b10);
        line.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            line.push_back(b[i]);
            p = p ^ b[i];
        end
        if (cfg_parity == 2'b01 || cfg_parity == 2'b10) line.push_back(p);
        line.push_back(1'b1);
        if (cfg_stop2) line.push_back(1'b1);
        foreach (line[i]) for (int k = 0; k < d; k++) wave.push_back(line[i]);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            wave.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_ovf = 1'b0;
        end else begin
            int c;
            c = mq.size();
            m_tx   = (wave.size() != 0) ? wave[0] : 1'b1;
            m_busy = (wave.size() != 0);
            if (wave.size() != 0) void'(wave.pop_front());
            m_ovf = wr_en && (c == DEPTH);
            if (c > 0 && wave.size() == 0) build(mq.pop_front());
            if (wr_en && c < DEPTH) mq.push_back(wr_data);
        end
    end

    int peak = 0;
    int ovf_seen = 0;
    always @(negedge clk) begin
        chk("tx", int'(tx), int'(m_tx));
        chk("busy", int'(tx_busy), int'(m_busy));
        chk("count", int'(fifo_count), mq.size());
        chk("full", int'(fifo_full), int'(mq.size() == DEPTH));
        chk("empty", int'(fifo_empty), int'(mq.size() == 0));
        chk("ovf", int'(overflow), int'(m_ovf));
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (overflow) ovf_seen++;
    end

    task automatic set_cfg(input int d, input logic [1:0] db, input logic [1:0] par, input logic s2);
        @(negedge clk);
        cfg_clk_per_bit = CNT_W'(d);
        cfg_data_bits = db; cfg_parity = par; cfg_stop2 = s2;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); wr_en = 1'b1; wr_data = b;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic capture(input int d, input int nbits, output int lat,
                           output logic [15:0] bits, output int busy);
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin @(negedge clk); lat++; end
        bits = '1; busy = 0;
        for (int i = 0; i < nbits * d; i++) begin
            if (i % d == 0) bits[i / d] = tx;
            if (tx_busy) busy++;
            @(negedge clk);
        end
        while (tx_busy && busy < 5000) begin busy++; @(negedge clk); end
    endtask

    initial begin
        int lat, busy, n;
        logic [15:0] bits;
        reset_n = 1'b0; wr_en = 1'b0; wr_data = '0;
        cfg_clk_per_bit = '0; cfg_data_bits = '0; cfg_parity = '0; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_tx", int'(tx), 1);
        chk("idle_busy", int'(tx_busy), 0);
        chk("idle_count", int'(fifo_count), 0);
        chk("idle_full", int'(fifo_full), 0);

        // 8N1, D=4, 0xA5
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        send(8'hA5);
        capture(4, 10, lat, bits, busy);
        chk("a5_latency", lat, 2);
        chk("a5_bits", int'(bits[9:0]), 'h34A);
        chk("a5_busy", busy, 40);

        // 7E2, D=3, 0x83: bit 7 ignored, parity 0
        set_cfg(3, 2'b10, 2'b01, 1'b1);
        send(8'h83);
        capture(3, 11, lat, bits, busy);
        chk("7e2_bits", int'(bits[10:0]), 'h606);
        chk("7e2_busy", busy, 33);

        // 5O1, D=2, 0x1F: parity 0
        set_cfg(2, 2'b00, 2'b10, 1'b0);
        send(8'h1F);
        capture(2, 8, lat, bits, busy);
        chk("5o1_bits", int'(bits[7:0]), 'hBE);
        chk("5o1_busy", busy, 16);

        // divisor 0 behaves as 1
        set_cfg(0, 2'b11, 2'b00, 1'b0);
        send(8'h3C);
        capture(1, 10, lat, bits, busy);
        chk("d0_latency", lat, 2);
        chk("d0_bits", int'(bits[9:0]), 'h278);
        chk("d0_busy", busy, 10);

        // back-to-back streaming
        set_cfg(2, 2'b11, 2'b00, 1'b0);
        peak = 0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_data = 8'h33;
        @(negedge clk); wr_en = 1'b0;
        capture(2, 0, lat, bits, busy);
        chk("b2b_busy", busy, 60);
        chk("b2b_peak", peak, 2);

        // overflow on the 10th write
        set_cfg(100, 2'b11, 2'b00, 1'b0);
        peak = 0; ovf_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
        end
        @(negedge clk); wr_en = 1'b0;
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_full", int'(fifo_full), 1);
        chk("ovf_peak", peak, DEPTH);
        n = 0;
        while ((tx_busy || !fifo_empty) && n < 20000) begin @(negedge clk); n++; end
        chk("ovf_drain_timeout", int'(n >= 20000), 0);
        chk("ovf_once", ovf_seen, 1);

        // reset in the middle of the data bits
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
        @(negedge clk); wr_data = 8'h55;
        @(negedge clk); wr_en = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("mid_data_low", int'(tx), 0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tx", int'(tx), 1);
        chk("arst_busy", int'(tx_busy), 0);
        chk("arst_empty", int'(fifo_empty), 1);
        chk("arst_count", int'(fifo_count), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_tx", int'(tx), 1);
        chk("post_busy", int'(tx_busy), 0);
        chk("post_empty", int'(fifo_empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds a write FIFO, runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and back-to-back frame streaming. It sits between the memory-mapped UART peripheral registers and the tx pin. Frame format and baud divisor are sampled per frame, so software can reconfigure between frames without glitching a frame in flight.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, 2..64.
CNT_W, 16, width of the baud divisor and bit-cycle counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous reset, active low (codebase `reset`, inverted polarity).
wr_en  input  1  push wr_data into FIFO this cycle.
wr_data  input  8  byte to send; bits above the active data length are ignored.
cfg_clk_per_bit  input  CNT_W  clock cycles per bit; 0 is treated as 1.
cfg_data_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8.
cfg_parity  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx  output  1  serial line; idle high.
tx_busy  output  1  a frame is on the line.
fifo_full  output  1  FIFO holds DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_count  output  $clog2(DEPTH)+1  current occupancy.
overflow  output  1  one-cycle pulse when wr_en is asserted while fifo_full.

Behaviour:
- Reset (async assert, sync release) sets tx=1, tx_busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, FSM=IDLE, pointers=0, and clears all counters.
- FIFO:
  - Write accepted only when wr_en and !fifo_full.
  - Write while full: data dropped, count unchanged, overflow=1 for exactly that cycle.
  - Pop and write in the same cycle: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - fifo_full and fifo_empty are registered and consistent with fifo_count every cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_busy=0. If !fifo_empty, pop the head entry and go to START on the next edge. In the same pop edge, latch the byte, data length, parity mode, stop count and divisor (0 latched as 1).
  - START: tx=0 for D cycles, where D is the latched divisor.
  - DATA: transmit N bits LSB first, each for D cycles.
  - PARITY (skipped when parity is none): tx = XOR of the N data bits (even), or its inverse (odd), for D cycles.
  - STOP: tx=1 for D cycles per stop bit (1 or 2).
  - End of the last stop bit:
    - If the FIFO is non-empty: pop and enter START directly. No idle gap; tx_busy stays 1.
    - Otherwise: go to IDLE.
  - tx_busy=1 in START, DATA, PARITY and STOP.
- Frame length in cycles = D × (1 + N + P + S), with P∈{0,1} and S∈{1,2}. Each bit is exactly D cycles.
- Latency: wr_en sampled at edge k into an empty FIFO with FSM in IDLE; the pop occurs at edge k+1; tx falls and tx_busy rises after edge k+2.
- cfg_* changes while busy have no effect on the current frame; they apply to the next pop.
- Counters: the bit-cycle counter is CNT_W wide and counts 0..D−1, so there is no overflow at D = 2^CNT_W−1. The bit index is 3 bits.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously) and the FIFO contents are discarded.
- tx is driven from a register. No combinational path from inputs to tx.

Test Plan:
- Reset with all inputs low, then release -> tx=1, tx_busy=0, fifo_empty=1, fifo_count=0; hold 20 cycles, no change.
- D=4, 8N1, write 0xA5 once -> tx falls 2 edges after the write; line sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles; tx_busy high for exactly 40 cycles.
- D=3, 7 data bits even parity 2 stop bits, write 0x83 -> data bits 1,1,0,0,0,0,0; parity 0; two stop bits; frame 33 cycles; bit 7 ignored.
- D=2, 5 data bits odd parity, write 0x1F -> data 1,1,1,1,1; parity 0.
- D=2, 8N1, write 3 bytes on consecutive cycles -> fifo_count peaks at 2; three frames back-to-back with no idle cycle between a stop bit and the next start bit; tx_busy continuous for 60 cycles.
- DEPTH=8, D=100: write 10 bytes in 10 cycles -> fifo_full asserted; overflow pulses exactly once, on the 10th write; that byte is never transmitted.
- Assert reset_n low mid-DATA -> tx=1 and tx_busy=0 within the same cycle, fifo_empty=1; after release, no residual frame.
